// File: rtl/fact_accel.sv
// fact_accel: memory-mapped iterative factorial accelerator.
// Firmware writes N, issues a start through CTRL, polls STATUS and reads
// RESULT. One multiply step is performed per clock while the FSM is in CALC.
// Operands above 12 are rejected with err because 13! does not fit in 32 bits.
//
// Optional feature: define FACT_ACCEL_IRQ_EN to add a registered done
// interrupt output 'irq'. Without it, completion is observed by polling STATUS.

module fact_accel (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd
`ifdef FACT_ACCEL_IRQ_EN
  ,
  output logic        irq
`endif
);

  // Word addresses within the block
  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  // Largest operand whose factorial still fits in 32 bits
  localparam logic [3:0] MAX_N = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT       state;
  stateT       stateNext;

  logic [3:0]  n;
  logic [3:0]  nNext;
  logic [3:0]  cnt;
  logic [3:0]  cntNext;
  logic [31:0] res;
  logic [31:0] resNext;
  logic        done;
  logic        doneNext;
  logic        err;
  logic        errNext;

  logic        busy;
  logic        wrN;
  logic        startCmd;
  logic        wrStatus;
  logic        enterDone;

  // Only the low nibble of wd is architecturally meaningful; upper bits are
  // deliberately discarded.
  logic        unusedWdBits;
  assign unusedWdBits = ^wd[31:4];

  assign busy = (state == CALC);

  // Bus write decode: every write that changes state is locked out while busy
  always_comb begin
    wrN      = 1'b0;
    startCmd = 1'b0;
    wrStatus = 1'b0;
    if (we && !busy) begin
      case (a)
        ADDR_N:      wrN      = 1'b1;
        ADDR_CTRL:   startCmd = wd[0];
        ADDR_STATUS: wrStatus = 1'b1;
        default:     ;
      endcase
    end
  end

  // Next-state and datapath update: start/abort handling, one multiply per CALC cycle
  always_comb begin
    stateNext = state;
    nNext     = n;
    cntNext   = cnt;
    resNext   = res;
    doneNext  = done;
    errNext   = err;
    enterDone = 1'b0;

    if (wrN) begin
      nNext = wd[3:0];
    end

    case (state)
      IDLE, DONE: begin
        if (startCmd) begin
          if (n > MAX_N) begin
            stateNext = DONE;
            resNext   = 32'd0;
            doneNext  = 1'b1;
            errNext   = 1'b1;
            enterDone = 1'b1;
          end else begin
            stateNext = CALC;
            resNext   = 32'd1;
            cntNext   = n;
            doneNext  = 1'b0;
            errNext   = 1'b0;
          end
        end else if (wrStatus) begin
          stateNext = IDLE;
          doneNext  = 1'b0;
          errNext   = 1'b0;
        end
      end

      CALC: begin
        if (cnt <= 4'd1) begin
          stateNext = DONE;
          doneNext  = 1'b1;
          enterDone = 1'b1;
        end else begin
          resNext = res * {28'd0, cnt};
          cntNext = cnt - 4'd1;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset also aborts a running calculation
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Operand, counter, result and status flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      n    <= 4'd0;
      cnt  <= 4'd0;
      res  <= 32'd0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      n    <= nNext;
      cnt  <= cntNext;
      res  <= resNext;
      done <= doneNext;
      err  <= errNext;
    end
  end

`ifdef FACT_ACCEL_IRQ_EN
  // Done interrupt: set with done, cleared by a STATUS write or a new start
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (enterDone) begin
      irq <= 1'b1;
    end else if (wrStatus || startCmd) begin
      irq <= 1'b0;
    end
  end
`endif

  // Combinational read mux over the four-word register map
  always_comb begin
    rd = 32'd0;
    case (a)
      ADDR_N:      rd = {28'd0, n};
      ADDR_CTRL:   rd = {31'd0, busy};
      ADDR_STATUS: rd = {30'd0, err, done};
      ADDR_RESULT: rd = res;
      default:     rd = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// tb_fact_accel: scoreboard bench for fact_accel.
// The driver issues bus writes/reads and pushes each read's expected value
// (from a register-level reference model) into a queue; a negedge monitor
// pops and compares whenever a read is presented.

module tb_fact_accel;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
`ifdef FACT_ACCEL_IRQ_EN
  logic        irq;
`endif

  logic        readReq;

  typedef struct {
    string       name;
    logic [31:0] expRd;
    logic        expIrq;
  } expT;

  expT expQ[$];

  int vectors;
  int miscompares;

  // Reference model state
  int mN;
  logic [31:0] mRes;
  bit mDone;
  bit mErr;
  bit mIrq;

  fact_accel dut (
    .clk(clk),
    .rst(rst),
    .we(we),
    .a(a),
    .wd(wd),
    .rd(rd)
`ifdef FACT_ACCEL_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "[TB] time limit reached");
  end

  // Scoreboard monitor: compares each presented read against the queued expectation
  always @(negedge clk) begin
    if (readReq) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL scoreboard-underflow: read presented at a=%0d with no expectation", a);
      end else begin
        expT e;
        e = expQ.pop_front();
        if (rd !== e.expRd) begin
          miscompares++;
          $display("[TB] FAIL %s: rd=0x%08h (%0d), required 0x%08h (%0d), expIrq=%0b",
                   e.name, rd, rd, e.expRd, e.expRd, e.expIrq);
        end
`ifdef FACT_ACCEL_IRQ_EN
        vectors++;
        if (irq !== e.expIrq) begin
          miscompares++;
          $display("[TB] FAIL %s-irq: irq=%0b, required %0b", e.name, irq, e.expIrq);
        end
`endif
      end
    end
  end

  // Plain-arithmetic factorial reference
  function automatic logic [31:0] factRef(input int k);
    longint r;
    r = 1;
    for (int i = 2; i <= k; i++) r = r * i;
    return r[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a read of addr for one cycle and queue its expected value
  task automatic checkOutput(input logic [1:0] addr, input logic [31:0] expVal, input string name);
    expT e;
    e.name   = name;
    e.expRd  = expVal;
    e.expIrq = mIrq;
    a  = addr;
    we = 1'b0;
    readReq = 1'b1;
    expQ.push_back(e);
    tick();
    readReq = 1'b0;
  endtask

  // Issue a single-cycle write and apply its effect to the reference model
  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data, input bit busyNow);
    a  = addr;
    wd = data;
    we = 1'b1;
    tick();
    we = 1'b0;
    if (!busyNow) begin
      case (addr)
        2'd0: mN = int'(data[3:0]);
        2'd1: begin
          if (data[0]) begin
            if (mN > 12) begin
              mRes = 32'd0; mDone = 1'b1; mErr = 1'b1; mIrq = 1'b1;
            end else begin
              mDone = 1'b0; mErr = 1'b0; mIrq = 1'b0;
            end
          end
        end
        2'd2: begin
          mDone = 1'b0; mErr = 1'b0; mIrq = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput(2'd0, 32'(mN), {tag, "-N"});
    checkOutput(2'd1, 32'd0, {tag, "-CTRL"});
    checkOutput(2'd2, {30'd0, mErr, mDone}, {tag, "-STATUS"});
    checkOutput(2'd3, mRes, {tag, "-RESULT"});
  endtask

  task automatic modelReset();
    mN = 0; mRes = 32'd0; mDone = 1'b0; mErr = 1'b0; mIrq = 1'b0;
  endtask

  // Start a run with the current N; nIgnored busy cycles are spent on writes that must be ignored
  task automatic runFactorial(input int nIgnored);
    int bc;
    applyStimulus(2'd1, ($urandom() & 32'hFFFF_FFFE) | 32'd1, 1'b0);
    if (mN > 12) begin
      checkOutput(2'd1, 32'd0, "err-busy");
      checkOutput(2'd2, 32'd3, "err-status");
      checkOutput(2'd3, 32'd0, "err-result");
    end else begin
      bc = (mN <= 1) ? 1 : mN;
      for (int j = 0; j < bc; j++) begin
        if (j < nIgnored) begin
          case (j % 3)
            0: applyStimulus(2'd0, 32'd3, 1'b1);
            1: applyStimulus(2'd2, $urandom(), 1'b1);
            default: applyStimulus(2'd1, 32'd1, 1'b1);
          endcase
        end else begin
          checkOutput(2'd1, 32'd1, $sformatf("busy-n%0d-c%0d", mN, j));
        end
      end
      mRes = factRef(mN); mDone = 1'b1; mIrq = 1'b1;
      checkOutput(2'd1, 32'd0, $sformatf("idle-n%0d", mN));
      checkOutput(2'd2, 32'd1, $sformatf("status-n%0d", mN));
      checkOutput(2'd3, mRes, $sformatf("result-n%0d", mN));
      checkOutput(2'd0, 32'(mN), $sformatf("nreg-n%0d", mN));
    end
  endtask

  initial begin
    int nr;
    vectors = 0;
    miscompares = 0;
    readReq = 1'b0;
    we = 1'b0;
    a = 2'd0;
    wd = 32'd0;
    rst = 1'b1;
    modelReset();
    tick();
    tick();
    rst = 1'b0;
    checkAll("reset");

    // Directed runs
    applyStimulus(2'd0, 32'd5, 1'b0);  runFactorial(0);
    applyStimulus(2'd0, 32'd12, 1'b0); runFactorial(0);
    applyStimulus(2'd0, 32'd0, 1'b0);  runFactorial(0);
    applyStimulus(2'd0, 32'd1, 1'b0);  runFactorial(0);
    applyStimulus(2'd0, 32'd13, 1'b0); runFactorial(0);
    applyStimulus(2'd2, 32'd0, 1'b0);
    checkOutput(2'd2, 32'd0, "err-cleared");
    checkOutput(2'd3, 32'd0, "err-result-kept");

    // Writes during CALC must be ignored
    applyStimulus(2'd0, 32'd7, 1'b0);  runFactorial(3);

    // Reset mid-calculation
    applyStimulus(2'd0, 32'd10, 1'b0);
    applyStimulus(2'd1, 32'd1, 1'b0);
    for (int j = 0; j < 3; j++) checkOutput(2'd1, 32'd1, "busy-before-abort");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    checkAll("abort");
    applyStimulus(2'd0, 32'd4, 1'b0);  runFactorial(0);
    applyStimulus(2'd2, 32'd0, 1'b0);
    checkOutput(2'd2, 32'd0, "status-cleared");
    checkOutput(2'd3, 32'd24, "result-kept");

    // Randomized runs against the reference model
    for (int it = 0; it < 12; it++) begin
      nr = $urandom_range(0, 15);
      applyStimulus(2'd0, ($urandom() & 32'hFFFF_FFF0) | 32'(nr), 1'b0);
      checkOutput(2'd0, 32'(nr), "rand-nreg");
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(2'd3, $urandom(), 1'b0);
        checkOutput(2'd3, mRes, "rand-result-ro");
      end
      runFactorial(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(2'd2, $urandom(), 1'b0);
        checkOutput(2'd2, 32'd0, "rand-status-clr");
      end
    end

    // Drain: every queued expectation must have been consumed
    for (int k = 0; k < 5 && expQ.size() != 0; k++) tick();
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard-drain: %0d expectations left, required 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
